// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life display path:
// sequencer state encoding and the GRB pixel packing used on the WS2812 wire.
package life_pkg;

    localparam int BITS_PER_PIXEL     = 24;
    localparam int BIT_CNT_W          = 5;
    localparam int DEFAULT_NUM_PIXELS = 64;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        WAIT,
        LATCH,
        DONE
    } seq_state_t;

    // WS2812 expects green first, then red, then blue, each MSB first.
    typedef struct packed {
        logic [7:0] green;
        logic [7:0] red;
        logic [7:0] blue;
    } grb_pixel_t;

    function automatic grb_pixel_t pack_grb(input logic [7:0] red,
                                            input logic [7:0] green,
                                            input logic [7:0] blue);
        grb_pixel_t pix;
        pix.green = green;
        pix.red   = red;
        pix.blue  = blue;
        return pix;
    endfunction

endpackage

// File: rtl/pixel_serializer.sv
// 24-bit pixel shift register with bit counter; presents the MSB to the
// encoder and flags when the final bit of the pixel is on the line.
module pixel_serializer
    import life_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      shift,
    input  logic                      clear,
    input  logic [BITS_PER_PIXEL-1:0] load_data,
    output logic                      pixel_value,
    output logic                      last_bit
);

    logic [BITS_PER_PIXEL-1:0] sreg_reg;
    logic [BITS_PER_PIXEL-1:0] sreg_next;
    logic [BITS_PER_PIXEL-1:0] shifted;
    logic [BIT_CNT_W-1:0]      bit_cnt_reg;
    logic [BIT_CNT_W-1:0]      bit_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_PIXEL; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = 1'b0;
            end else begin : g_upper
                assign shifted[gi] = sreg_reg[gi-1];
            end
        end
    endgenerate

    // clear wins so the line is forced low as soon as the frame ends
    always_comb begin
        sreg_next    = sreg_reg;
        bit_cnt_next = bit_cnt_reg;
        if (clear) begin
            sreg_next    = '0;
            bit_cnt_next = '0;
        end else if (load) begin
            sreg_next    = load_data;
            bit_cnt_next = '0;
        end else if (shift) begin
            sreg_next    = shifted;
            bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_reg    <= '0;
            bit_cnt_reg <= '0;
        end else begin
            sreg_reg    <= sreg_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    assign pixel_value = sreg_reg[BITS_PER_PIXEL-1];
    assign last_bit    = (bit_cnt_reg == BIT_CNT_W'(BITS_PER_PIXEL - 1));

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Walks the pixel RAM once per frame request and feeds each GRB bit to the
// WS2812 encoder, then holds the line low for the latch gap.
module pixel_frame_sequencer
    import life_pkg::*;
#(
    parameter int NUM_PIXELS   = DEFAULT_NUM_PIXELS,
    parameter int ADDR_W       = 6,
    parameter int LATCH_CYCLES = 3600
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        red_data,
    input  logic [7:0]        green_data,
    input  logic [7:0]        blue_data,
    input  logic              bit_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              load_sreg,
    output logic              transmit_pixel,
    output logic              pixel_value,
    output logic              busy,
    output logic              frame_done
);

    localparam int LATCH_W = $clog2(LATCH_CYCLES);

    seq_state_t         state_reg;
    seq_state_t         state_next;
    logic [ADDR_W-1:0]  pix_idx_reg;
    logic [ADDR_W-1:0]  pix_idx_next;
    logic [LATCH_W-1:0] latch_cnt_reg;
    logic [LATCH_W-1:0] latch_cnt_next;
    logic               last_bit;
    logic               last_pixel;
    logic               latch_end;
    logic               ser_load;
    logic               ser_shift;
    logic               ser_clear;
    grb_pixel_t         fetched;

    assign last_pixel = (pix_idx_reg == ADDR_W'(NUM_PIXELS - 1));
    assign latch_end  = (latch_cnt_reg == LATCH_W'(LATCH_CYCLES - 1));
    assign fetched    = pack_grb(red_data, green_data, blue_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    state_next = WAIT;
            WAIT: begin
                if (bit_done) begin
                    if (!last_bit) begin
                        state_next = SEND;
                    end else if (!last_pixel) begin
                        state_next = FETCH;
                    end else begin
                        state_next = LATCH;
                    end
                end
            end
            LATCH:   if (latch_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_sreg      = (state_reg == LOAD);
        transmit_pixel = (state_reg == SEND);
        busy           = (state_reg != IDLE);
        frame_done     = (state_reg == DONE);
        ser_load       = (state_reg == LOAD);
        ser_shift      = (state_reg == WAIT) && bit_done && !last_bit;
        ser_clear      = (state_reg == WAIT) && bit_done && last_bit && last_pixel;
    end

    // Address is cleared while leaving DONE so IDLE already presents 0.
    always_comb begin
        pix_idx_next   = pix_idx_reg;
        latch_cnt_next = '0;
        if (state_reg == IDLE || state_reg == DONE) begin
            pix_idx_next = '0;
        end else if (state_reg == WAIT && bit_done && last_bit && !last_pixel) begin
            pix_idx_next = pix_idx_reg + ADDR_W'(1);
        end
        if (state_reg == LATCH) begin
            latch_cnt_next = latch_cnt_reg + LATCH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_idx_reg   <= '0;
            latch_cnt_reg <= '0;
        end else begin
            pix_idx_reg   <= pix_idx_next;
            latch_cnt_reg <= latch_cnt_next;
        end
    end

    assign mem_address = pix_idx_reg;

    pixel_serializer u_serializer (
        .clk         (clk),
        .reset       (reset),
        .load        (ser_load),
        .shift       (ser_shift),
        .clear       (ser_clear),
        .load_data   (fetched),
        .pixel_value (pixel_value),
        .last_bit    (last_bit)
    );

endmodule

// File: doc/pixel_frame_sequencer.md
# pixel_frame_sequencer

Sequences one full frame of the 8x8 display out to the WS2812 bit encoder. On a start request it walks all 64 pixel addresses of the pixel RAM and captures each pixel's GRB colour into a 24-bit shift register. It then hands the bits one at a time, MSB first, to the encoder, holds the line idle for the latch gap, and signals frame completion. It sits between the Game of Life generation logic (which requests frames) and the single-wire encoder.

## Interface
- NUM_PIXELS, 64, pixels per frame; mem_address walks 0..NUM_PIXELS-1
- ADDR_W, 6, width of mem_address; must satisfy 2**ADDR_W >= NUM_PIXELS
- LATCH_CYCLES, 3600, idle cycles after the last bit (300 us at 12 MHz)
- clk  input  1  system clock, 12 MHz
- reset  input  1  synchronous, active-high reset
- start  input  1  frame request; sampled only in IDLE
- red_data  input  8  pixel RAM red byte, valid 1 cycle after mem_address
- green_data  input  8  pixel RAM green byte, same timing as red_data
- blue_data  input  8  pixel RAM blue byte, same timing as red_data
- bit_done  input  1  1-cycle pulse from the encoder when the current bit waveform ends
- mem_address  output  ADDR_W  pixel RAM read address
- load_sreg  output  1  1-cycle pulse when RAM data is captured into the shift register
- transmit_pixel  output  1  1-cycle strobe that starts the encoder on pixel_value
- pixel_value  output  1  current bit; always equals shift-register bit 23
- busy  output  1  high in every state except IDLE
- frame_done  output  1  1-cycle pulse at the end of the latch gap

## Operation
- States: IDLE, FETCH, LOAD, SEND, WAIT, LATCH, DONE.
- IDLE: pix_idx=0, bit_cnt=0. If start=1, go to FETCH. A start received while busy is ignored, not queued.
- FETCH: mem_address=pix_idx. Go to LOAD.
- LOAD: load_sreg=1; sreg <= {green_data, red_data, blue_data}; bit_cnt <= 0. Go to SEND.
- SEND: transmit_pixel=1. Go to WAIT.
- WAIT: hold sreg and pixel_value stable. On bit_done:
  - If bit_cnt<23: sreg <= sreg<<1, bit_cnt++, go to SEND.
  - Else if pix_idx<NUM_PIXELS-1: pix_idx++, go to FETCH.
  - Else: go to LATCH with the latch counter at 0.
- bit_done outside WAIT is ignored.
- LATCH: sreg=0 so pixel_value=0, no strobes. The counter increments each cycle. When the counter reaches LATCH_CYCLES-1, go to DONE.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- Widths: bit_cnt is 5 bits. The latch counter is $clog2(LATCH_CYCLES) bits. pix_idx is ADDR_W bits and never wraps within a frame.
- mem_address holds its last value outside FETCH/LOAD. It returns to 0 in IDLE.

## Timing
- Reset (takes priority over everything, including mid-frame): state=IDLE and every output 0 (mem_address=0, load_sreg=0, transmit_pixel=0, pixel_value=0, busy=0, frame_done=0). sreg, bit_cnt, pix_idx and the latch counter are also cleared. The encoder is never strobed again for the aborted frame.
- Start accepted at cycle 0: FETCH at cycle 1 with mem_address=0, load_sreg at cycle 2, first transmit_pixel at cycle 3.
- Bit turnaround: bit_done at cycle t gives the next transmit_pixel at t+1 within a pixel. Across a pixel boundary it is t+3 (FETCH, LOAD, SEND).
- pixel_value changes only on the cycle after LOAD or after an accepted bit_done. It is therefore stable from each transmit_pixel until the matching bit_done.
- Last bit_done at cycle t: LATCH spans t+1..t+LATCH_CYCLES, frame_done pulses at t+LATCH_CYCLES+1, IDLE follows.
- busy rises the cycle after start and falls the cycle after frame_done.
- start may be asserted in the same cycle the block returns to IDLE; it is accepted the cycle after.
- Exactly 24*NUM_PIXELS transmit_pixel pulses are issued per frame (1536 by default).

## Structure
- Shared package life_pkg holds: the state enum (IDLE..DONE), BITS_PER_PIXEL=24, the default NUM_PIXELS=64, and the GRB packing order.
- One natural sub-module: pixel_serializer, containing the 24-bit shift register and the 5-bit bit counter. It takes load/shift inputs and gives pixel_value and last_bit outputs. The FSM, address counter and latch counter stay in the top module.

## Test plan
- Reset then idle: hold reset 3 cycles, then start=0 for 100 cycles -> all outputs 0, no strobes.
- Single pixel pattern: RAM[0]={G=8'hFF, R=8'h00, B=8'hA5}, other pixels 0. The bench encoder returns bit_done 15 cycles after each strobe -> first 24 captured bits are 1111_1111_0000_0000_1010_0101. The total of 1536 strobes is followed by frame_done exactly LATCH_CYCLES+1 cycles after the last bit_done.
- Address walk: glider in red at addresses 10, 19, 25, 26, 27 -> mem_address visits 0..63 in order, each once. load_sreg pulses 64 times, and red bits are 1 only for those pixels.
- Spurious handshake: pulse bit_done during SEND, LATCH and IDLE, and start during WAIT -> no extra shifts, no second frame, strobe count stays 1536.
- Reset mid-frame: assert reset during pixel 30, bit 12 -> next cycle all outputs 0. A new start then begins at mem_address=0 with bit 23 of pixel 0.
- Back-to-back: start held high continuously -> consecutive frames separated by exactly one IDLE cycle after frame_done, with identical strobe sequences.
